sp_ram_responder: RTL and testbench
===================================

// Module: sp_ram_responder
//
// PURPOSE
//  Responder end of the single-port RAM request interface: accepts en/valid/wr_rd/addr/din
//  requests from an initiator, performs the write or read on internal storage, and returns
//  dout/ready/error. Synthesizable DUT sitting behind the RAM interface in the verification env.
//
// PARAMETERS
//  ADDR_WIDTH  8    address width; must match `ADDR_WIDTH of the interface
//  DATA_WIDTH  32   data width; must match `DATA_WIDTH of the interface
//  DEPTH       256  implemented words; addr >= DEPTH is out of range (DEPTH <= 2**ADDR_WIDTH)
//  LATENCY     2    busy cycles per access, >= 1
//
// PORTS
//  clk     in   1           clock, all logic on posedge
//  rst     in   1           synchronous, active-high reset
//  en      in   1           request enable
//  wr_rd   in   1           1 = write, 0 = read
//  addr    in   ADDR_WIDTH  word address
//  din     in   DATA_WIDTH  write data
//  valid   in   1           request valid; a request exists only when en && valid
//  dout    out  DATA_WIDTH  read data, valid and held while ready=1 after a read
//  ready   out  1           responder idle, can accept a request
//  error   out  1           last completed access failed; held with dout
//
// BEHAVIOUR
//  - Reset (rst=1 at an edge): ready=0, dout=0, error=0, FSM=IDLE, busy counter=0. Memory
//    contents NOT cleared. First edge with rst=0: ready=1. rst mid-access aborts it: a pending
//    write is dropped if not yet committed, read result discarded.
//  - FSM: IDLE (ready=1) -> BUSY on acceptance; BUSY counts LATENCY-1 down to 0, -> IDLE.
//  - Acceptance: edge where en && valid && ready. Sample wr_rd/addr/din there; ready=0 next cycle.
//    en without valid, valid without en, or any request while ready=0: ignored, no state change.
//  - Latency: ready returns to 1 exactly LATENCY cycles after the acceptance edge; dout/error
//    update on that same edge and hold until the next completion.
//  - Write: memory[addr] <= din on the completion edge; dout unchanged.
//  - Read: dout <= memory[addr] on completion; write-then-read same addr returns new data.
//  - Out of range (addr >= DEPTH): no memory change, dout <= 0, error <= 1.
//  - In-range access without fault: error <= 0.
//  - Back-to-back: request held with ready=1 on completion edge is accepted on the next edge.
//
// CONFIGURATION
//  SP_RAM_PARITY_EN defined: each word stores one even-parity bit; extra input port
//    par_inj (1 bit) flips the stored parity bit on an accepted write with par_inj=1.
//    Read with parity mismatch: dout <= stored data, error <= 1. Writes recompute parity.
//  SP_RAM_PARITY_EN undefined: no parity storage, no par_inj port; error only on out of range.
//
// STRUCTURE
//  - sp_ram_pkg: typedef enum {IDLE, BUSY} state_t; localparams OP_WR=1'b1, OP_RD=1'b0;
//    function even_parity(data).
//  - Sub-module sp_ram_array: storage (DEPTH x DATA_WIDTH[+1]), single write/read port,
//    registered read; top holds FSM, latency counter, range and parity check.
//
// TESTING
//  1 Reset: rst=1 3 cycles -> ready=0,dout=0,error=0; 1 cycle after rst=0 -> ready=1.
//  2 Write 0xDEADBEEF @0x10, then read @0x10 (LATENCY=2) -> ready low 2 cycles each,
//    dout=0xDEADBEEF, error=0 on read completion.
//  3 DEPTH=200: read @0xC8 -> error=1, dout=0; write @0xC8 then read @0x00 -> memory intact.
//  4 en=1,valid=0 and en=0,valid=1 for 5 cycles -> ready stays 1, dout/error unchanged.
//  5 rst=1 one cycle after accepting write 0x1234 @0x20 -> ready=0; read @0x20 returns old value.
//  6 SP_RAM_PARITY_EN: write 0x5 @0x3 with par_inj=1, read @0x3 -> dout=0x5, error=1;
//    rewrite with par_inj=0, read -> error=0.

Source files
------------

// File: rtl/sp_ram_pkg.sv
// Shared types, opcodes and the parity helper for the single-port RAM responder.
package sp_ram_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   localparam logic OP_WR = 1'b1;
   localparam logic OP_RD = 1'b0;

   // Widest data word the parity helper accepts; callers zero-extend into it.
   localparam int MAX_DW = 64;

   // Returns the bit that makes the total count of ones (data plus this bit) even.
   function automatic logic even_parity(input logic [MAX_DW-1:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/sp_ram_array.sv
// Single-port storage with one shared address: synchronous write, registered read.
module sp_ram_array #(
   parameter int ADDR_WIDTH = 8,
   parameter int WORD_WIDTH = 32,
   parameter int DEPTH      = 256
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic                  re,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [WORD_WIDTH-1:0] wdata,
   output logic [WORD_WIDTH-1:0] rdata
);

   logic [WORD_WIDTH-1:0] mem [DEPTH];

   // NOTE: storage and its read register carry no reset; contents survive rst so
   // the array maps onto plain RAM macros without a clear sequence.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      if (re) begin
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/sp_ram_responder.sv
// Responder behind the single-port RAM request interface: FSM, latency counter,
// range check. Define SP_RAM_PARITY_EN to add per-word even parity and the par_inj port.
module sp_ram_responder
   import sp_ram_pkg::*;
#(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 256,
   parameter int LATENCY    = 2
) (
   input  logic                  clk,
   input  logic                  rst,
`ifdef SP_RAM_PARITY_EN
   input  logic                  par_inj,
`endif
   input  logic                  en,
   input  logic                  wr_rd,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic                  valid,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  ready,
   output logic                  error
);

   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
`ifdef SP_RAM_PARITY_EN
   localparam int WW = DATA_WIDTH + 1;
`else
   localparam int WW = DATA_WIDTH;
`endif
   localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

   state_t                state;
   logic [CW-1:0]         cnt;
   logic                  op_q;
   logic                  range_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] din_q;

   logic                  accept;
   logic                  complete;
   logic                  addr_ok;
   logic                  rd_par_bad;
   logic                  arr_we;
   logic                  arr_re;
   logic [ADDR_WIDTH-1:0] arr_addr;
   logic [WW-1:0]         arr_wdata;
   logic [WW-1:0]         arr_rdata;

   assign addr_ok  = {1'b0, addr} < DEPTH_W;
   assign accept   = ready && en && valid;
   assign complete = (state == BUSY) && (cnt == '0);

   // Reads are issued on the acceptance edge so the registered array output is
   // ready by completion; writes commit on the completion edge unless reset hits it.
   assign arr_we   = !rst && complete && (op_q == OP_WR) && range_q;
   assign arr_re   = !rst && accept && (wr_rd == OP_RD) && addr_ok;
   assign arr_addr = complete ? addr_q : addr;

`ifdef SP_RAM_PARITY_EN
   logic par_inj_q;

   always_ff @(posedge clk) begin
      if (accept) begin
         par_inj_q <= par_inj;
      end
   end

   assign arr_wdata  = {even_parity(MAX_DW'(din_q)) ^ par_inj_q, din_q};
   assign rd_par_bad = arr_rdata[DATA_WIDTH] != even_parity(MAX_DW'(arr_rdata[DATA_WIDTH-1:0]));
`else
   assign arr_wdata  = din_q;
   assign rd_par_bad = 1'b0;
`endif

   sp_ram_array #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .WORD_WIDTH (WW),
      .DEPTH      (DEPTH)
   ) u_array (
      .clk   (clk),
      .we    (arr_we),
      .re    (arr_re),
      .addr  (arr_addr),
      .wdata (arr_wdata),
      .rdata (arr_rdata)
   );

   // NOTE: all state updates use non-blocking assignments so every register
   // samples pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk) begin
      if (accept) begin
         op_q    <= wr_rd;
         addr_q  <= addr;
         din_q   <= din;
         range_q <= addr_ok;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         ready <= 1'b0;
         dout  <= '0;
         error <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  state <= BUSY;
                  cnt   <= CW'(LATENCY - 1);
                  ready <= 1'b0;
               end else begin
                  ready <= 1'b1;
               end
            end
            BUSY: begin
               if (cnt == '0) begin
                  state <= IDLE;
                  ready <= 1'b1;
                  if (!range_q) begin
                     dout  <= '0;
                     error <= 1'b1;
                  end else if (op_q == OP_RD) begin
                     dout  <= arr_rdata[DATA_WIDTH-1:0];
                     error <= rd_par_bad;
                  end else begin
                     error <= 1'b0;
                  end
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sp_ram_responder.sv
// Self-checking bench for sp_ram_responder: transaction-level model plus directed and random stimulus.
module tb_sp_ram_responder;

   localparam int TB_DEPTH = 200;
   localparam int LAT      = 2;

   logic        clk;
   logic        rst;
   logic        en;
   logic        wr_rd;
   logic [7:0]  addr;
   logic [31:0] din;
   logic        valid;
   logic [31:0] dout;
   logic        ready;
   logic        error;
`ifdef SP_RAM_PARITY_EN
   logic        par_inj;
`endif

   int n_chk = 0;
   int n_err = 0;

   sp_ram_responder #(
      .ADDR_WIDTH (8),
      .DATA_WIDTH (32),
      .DEPTH      (TB_DEPTH),
      .LATENCY    (LAT)
   ) dut (
      .clk     (clk),
      .rst     (rst),
`ifdef SP_RAM_PARITY_EN
      .par_inj (par_inj),
`endif
      .en      (en),
      .wr_rd   (wr_rd),
      .addr    (addr),
      .din     (din),
      .valid   (valid),
      .dout    (dout),
      .ready   (ready),
      .error   (error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction model: a request accepted at cycle c completes at cycle c+LAT.
   logic [31:0] m_mem   [256];
   bit          m_known [256];
   bit          m_pbad  [256];
   logic        m_ready;
   logic [31:0] m_dout;
   logic        m_err;
   bit          m_dout_known;
   bit          m_on;
   bit          m_busy;
   longint      m_cycle;
   longint      m_due;
   logic        m_wr;
   logic [7:0]  m_addr;
   logic [31:0] m_din;
   bit          m_inj;

   initial begin
      for (int i = 0; i < 256; i++) begin
         m_known[i] = 0;
         m_pbad[i]  = 0;
      end
      m_on = 0; m_busy = 0; m_cycle = 0; m_due = 0;
      forever begin
         @(posedge clk);
         m_cycle++;
         if (rst) begin
            m_ready = 0; m_dout = 0; m_err = 0; m_dout_known = 1;
            m_busy = 0; m_on = 1;
         end else if (m_on) begin
            if (m_busy) begin
               if (m_cycle == m_due) begin
                  m_busy  = 0;
                  m_ready = 1;
                  if (int'(m_addr) >= TB_DEPTH) begin
                     m_dout = 0; m_err = 1; m_dout_known = 1;
                  end else if (m_wr) begin
                     m_mem[m_addr] = m_din; m_known[m_addr] = 1; m_pbad[m_addr] = m_inj;
                     m_err = 0;
                  end else begin
                     m_dout = m_mem[m_addr]; m_dout_known = m_known[m_addr];
                     m_err = m_pbad[m_addr];
                  end
               end
            end else if (m_ready && en && valid) begin
               m_busy = 1; m_due = m_cycle + LAT; m_ready = 0;
               m_wr = wr_rd; m_addr = addr; m_din = din;
`ifdef SP_RAM_PARITY_EN
               m_inj = par_inj && wr_rd;
`else
               m_inj = 0;
`endif
            end else begin
               m_ready = 1;
            end
         end
      end
   end

   // Per-cycle compare against the model, away from the active edge.
   initial begin
      forever begin
         @(negedge clk);
         if (m_on) begin
            check("ready", {31'd0, ready}, {31'd0, m_ready});
            check("error", {31'd0, error}, {31'd0, m_err});
            if (m_dout_known) check("dout", dout, m_dout);
         end
      end
   end

   task automatic wait_ready();
      int k = 0;
      while (ready !== 1'b1 && k < 50) begin
         @(negedge clk);
         k++;
      end
      if (ready !== 1'b1) check("wait_ready_timeout", {31'd0, ready}, 32'd1);
   endtask

   task automatic issue(input logic w, input logic [7:0] a, input logic [31:0] d, input logic inj);
      wait_ready();
      en = 1'b1; valid = 1'b1; wr_rd = w; addr = a; din = d;
`ifdef SP_RAM_PARITY_EN
      par_inj = inj;
`else
      if (inj) din = d;
`endif
      @(negedge clk);
      en = 1'b0; valid = 1'b0;
   endtask

   task automatic wait_done(input bit junk, output int lat);
      lat = 0;
      while (ready !== 1'b1 && lat < 50) begin
         if (junk) begin
            en = 1'($urandom); valid = 1'($urandom); wr_rd = 1'($urandom);
            addr = 8'($urandom); din = $urandom;
         end
         @(negedge clk);
         lat++;
      end
      en = 1'b0; valid = 1'b0;
   endtask

   task automatic do_req(input logic w, input logic [7:0] a, input logic [31:0] d,
                         input logic inj, input bit junk);
      int lat;
      issue(w, a, d, inj);
      wait_done(junk, lat);
      check("latency", 32'(lat), 32'(LAT));
   endtask

   function automatic logic [31:0] fill_val(input logic [7:0] a);
      return {a, a, a, a} ^ 32'hA5A5A5A5;
   endfunction

   initial begin
      logic [31:0] d0;
      logic        e0;
      rst = 1'b1; en = 1'b0; valid = 1'b0; wr_rd = 1'b0; addr = '0; din = '0;
`ifdef SP_RAM_PARITY_EN
      par_inj = 1'b0;
`endif
      // Reset held three cycles.
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ready", {31'd0, ready}, 32'd0);
      check("rst_dout", dout, 32'd0);
      check("rst_error", {31'd0, error}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("ready_after_rst", {31'd0, ready}, 32'd1);

      for (int a = 0; a < TB_DEPTH; a++) do_req(1'b1, 8'(a), fill_val(8'(a)), 1'b0, 1'b0);

      // Write then read back.
      do_req(1'b1, 8'h10, 32'hDEADBEEF, 1'b0, 1'b0);
      do_req(1'b0, 8'h10, 32'h0, 1'b0, 1'b0);
      check("rd_10_dout", dout, 32'hDEADBEEF);
      check("rd_10_error", {31'd0, error}, 32'd0);

      // Out of range just past DEPTH and at the top of the address space.
      do_req(1'b0, 8'hC8, 32'h0, 1'b0, 1'b0);
      check("oor_rd_dout", dout, 32'd0);
      check("oor_rd_error", {31'd0, error}, 32'd1);
      do_req(1'b1, 8'hC8, 32'hCAFEF00D, 1'b0, 1'b0);
      check("oor_wr_error", {31'd0, error}, 32'd1);
      do_req(1'b0, 8'h00, 32'h0, 1'b0, 1'b0);
      check("rd_00_dout", dout, 32'hA5A5A5A5);
      check("rd_00_error", {31'd0, error}, 32'd0);
      do_req(1'b0, 8'hC7, 32'h0, 1'b0, 1'b0);
      check("rd_c7_dout", dout, 32'h62626262);
      do_req(1'b0, 8'hFF, 32'h0, 1'b0, 1'b0);
      check("oor_ff_error", {31'd0, error}, 32'd1);

      // Partial requests are ignored.
      d0 = dout; e0 = error;
      for (int p = 0; p < 2; p++) begin
         en = (p == 0); valid = (p != 0); wr_rd = 1'b1; addr = 8'h05; din = 32'h11111111;
         repeat (5) begin
            @(negedge clk);
            check("partial_ready", {31'd0, ready}, 32'd1);
            check("partial_dout", dout, d0);
            check("partial_error", {31'd0, error}, {31'd0, e0});
         end
      end
      en = 1'b0; valid = 1'b0;

      // Reset one cycle after accepting a write aborts it.
      issue(1'b1, 8'h20, 32'h00001234, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      check("abort_ready", {31'd0, ready}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("abort_ready_back", {31'd0, ready}, 32'd1);
      do_req(1'b0, 8'h20, 32'h0, 1'b0, 1'b0);
      check("abort_rd_20", dout, 32'h85858585);

`ifdef SP_RAM_PARITY_EN
      do_req(1'b1, 8'h03, 32'h5, 1'b1, 1'b0);
      do_req(1'b0, 8'h03, 32'h0, 1'b0, 1'b0);
      check("par_bad_dout", dout, 32'h5);
      check("par_bad_error", {31'd0, error}, 32'd1);
      do_req(1'b1, 8'h03, 32'h5, 1'b0, 1'b0);
      do_req(1'b0, 8'h03, 32'h0, 1'b0, 1'b0);
      check("par_ok_error", {31'd0, error}, 32'd0);
`endif

      // Random traffic with ignored requests during busy and partial requests while idle.
      for (int t = 0; t < 400; t++) begin
         int gap;
         gap = int'($urandom_range(0, 2));
         for (int g = 0; g < gap; g++) begin
            en = 1'($urandom); valid = ~en; addr = 8'($urandom); din = $urandom;
            @(negedge clk);
         end
         en = 1'b0; valid = 1'b0;
         do_req(1'($urandom), 8'($urandom), $urandom, ($urandom_range(0, 3) == 0), 1'b1);
      end

      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
